// File: rtl/dcim_mac_array.sv
// Digital compute-in-memory MAC array: per-lane weight store, 2-stage multiply/accumulate pipeline.
// Optional build macro DCIM_APPROX_LSB_EN zeroes the APPROX_BITS product LSBs.

module dcim_mac_lane #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 32,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+$clog2(DEPTH),
    parameter int APPROX_BITS = 8,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  s1_vld,
    input  logic                  s1_mode,
    input  logic                  s1_last,
    output logic [ACC_WIDTH-1:0]  dout
);
`ifdef DCIM_APPROX_LSB_EN
    localparam int DROP = APPROX_BITS;
`else
    localparam int DROP = 0;
`endif

    logic [DATA_WIDTH-1:0]   weight_q [DEPTH];
    logic [2*DATA_WIDTH-1:0] prod_full, prod_d, prod_q;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d, dout_q, dout_d, sum;

    assign prod_full = (2*DATA_WIDTH)'(weight_q[addr]) * (2*DATA_WIDTH)'(din);
    assign prod_d    = (prod_full >> DROP) << DROP;
    assign sum       = acc_q + ACC_WIDTH'(prod_q);
    assign dout      = dout_q;

    // Weight storage survives reset; only a reload changes it.
    always_ff @(posedge clk) begin
        if (wr_en) weight_q[addr] <= din;
    end

    always_comb begin
        acc_d  = acc_q;
        dout_d = dout_q;
        if (flush) begin
            acc_d = '0;
        end else if (s1_vld) begin
            if (s1_mode) begin
                acc_d = s1_last ? '0 : sum;
                if (s1_last) dout_d = sum;
            end else begin
                dout_d = ACC_WIDTH'(prod_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
            dout_q <= '0;
        end else if (ce) begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            dout_q <= dout_d;
        end
    end
endmodule

module dcim_mac_array #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 32,
    parameter int LANES       = 2,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+$clog2(DEPTH),
    parameter int APPROX_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pe_ce,
    input  logic                        init_enable,
    input  logic                        mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] data_in,
    output logic [LANES*ACC_WIDTH-1:0]  data_out,
    output logic                        out_valid,
    output logic                        last_out,
    output logic                        init_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          init_done_q, init_done_d;
    logic          mode_q, mode_d, eff_mode;
    logic          xfer, cxfer, wr_en, flush;
    // vld_pipe_q[1]: product stage, vld_pipe_q[2]: output stage
    logic [2:1]    vld_pipe_q, vld_pipe_d;
    logic          s1_mode_q, s1_last_q, last_out_q, last_out_d;
    logic [LANES-1:0][ACC_WIDTH-1:0] lane_out;

    assign in_ready  = pe_ce && (state_q != IDLE);
    assign xfer      = in_valid && in_ready;
    // Mode is latched at the first word of a pass and held for the rest of it.
    assign eff_mode  = (addr_q == '0) ? mode : mode_q;
    assign out_valid = vld_pipe_q[2];
    assign last_out  = last_out_q;
    assign init_done = init_done_q;
    assign data_out  = lane_out;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        init_done_d = init_done_q;
        mode_d      = mode_q;
        flush       = 1'b0;
        wr_en       = 1'b0;
        cxfer       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pe_ce && init_enable) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d     = COMPUTE;
                        init_done_d = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (pe_ce && init_enable) begin
                    state_d     = LOAD;
                    addr_d      = '0;
                    init_done_d = 1'b0;
                    flush       = 1'b1;
                end else if (xfer) begin
                    cxfer  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    mode_d = eff_mode;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_pipe_d[1] = cxfer;
        vld_pipe_d[2] = vld_pipe_q[1] && !flush && (!s1_mode_q || s1_last_q);
        last_out_d    = vld_pipe_d[2] && s1_last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            mode_q      <= 1'b0;
            vld_pipe_q  <= '0;
            s1_mode_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            last_out_q  <= 1'b0;
        end else if (pe_ce) begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            mode_q      <= mode_d;
            vld_pipe_q  <= vld_pipe_d;
            s1_mode_q   <= eff_mode;
            s1_last_q   <= (addr_q == LAST_ADDR);
            last_out_q  <= last_out_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dcim_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .APPROX_BITS(APPROX_BITS),
            .AW         (AW)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .ce     (pe_ce),
            .flush  (flush),
            .wr_en  (wr_en),
            .addr   (addr_q),
            .din    (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .s1_vld (vld_pipe_q[1]),
            .s1_mode(s1_mode_q),
            .s1_last(s1_last_q),
            .dout   (lane_out[g])
        );
    end
endmodule

// File: tb/tb_dcim_mac_array.sv
// Scoreboard bench for dcim_mac_array: expected results queued at each accepted transfer, popped on out_valid.
module tb_dcim_mac_array;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n, pe_ce, init_enable, mode, in_valid;
    logic        in_ready, out_valid, last_out, init_done;
    logic [31:0] data_in;
    logic [73:0] data_out;

    always #5 clk = ~clk;

    dcim_mac_array #(.DATA_WIDTH(16), .DEPTH(32), .LANES(2), .ACC_WIDTH(37), .APPROX_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .pe_ce(pe_ce), .init_enable(init_enable), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .data_out(data_out),
        .out_valid(out_valid), .last_out(last_out), .init_done(init_done)
    );

    typedef struct {
        logic [73:0] data;
        logic        last;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          nvec = 0, nerr = 0, acnt = 0;
    logic        fresh = 1'b0;
    logic [15:0] wt0[DEPTH], wt1[DEPTH];
    int          maddr = 0;
    logic        mmode = 1'b0, tb_comp = 1'b0;
    logic [36:0] msum0 = '0, msum1 = '0;

    // Count active (pe_ce=1) edges; fresh marks outputs updated by the last edge.
    always @(posedge clk) begin
        fresh <= pe_ce;
        if (pe_ce) acnt <= acnt + 1;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && fresh && out_valid === 1'b1) begin
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL spurious_out: out_valid=1 data_out=%h with nothing expected", data_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out !== e.data || last_out !== e.last || acnt !== e.due) begin
                    nerr++;
                    $display("FAIL result: data_out got %h want %h, last_out got %b want %b, cycle got %0d want %0d",
                             data_out, e.data, last_out, e.last, acnt, e.due);
                end
            end
        end
    end

    function automatic logic [36:0] mprod(input logic [15:0] w, input logic [15:0] x);
        logic [31:0] p;
        p = 32'(w) * 32'(x);
`ifdef DCIM_APPROX_LSB_EN
        p[7:0] = '0;
`endif
        return {5'd0, p};
    endfunction

    task automatic model_xfer(input logic [15:0] d0, input logic [15:0] d1, input logic m);
        exp_t e;
        if (maddr == 0) mmode = m;
        if (!mmode) begin
            e.data = {mprod(wt1[maddr], d1), mprod(wt0[maddr], d0)};
            e.last = (maddr == DEPTH-1);
            e.due  = acnt + 2;
            q.push_back(e);
        end else begin
            msum0 = msum0 + mprod(wt0[maddr], d0);
            msum1 = msum1 + mprod(wt1[maddr], d1);
            if (maddr == DEPTH-1) begin
                e.data = {msum1, msum0};
                e.last = 1'b1;
                e.due  = acnt + 2;
                q.push_back(e);
                msum0 = '0;
                msum1 = '0;
            end
        end
        maddr = (maddr + 1) % DEPTH;
    endtask

    // One clock cycle of stimulus; acc reports whether the word was accepted.
    task automatic cyc(input logic v, input logic [15:0] d0, input logic [15:0] d1,
                       input logic m, input logic ce, output logic acc);
        in_valid = v;
        data_in  = {d1, d0};
        mode     = m;
        pe_ce    = ce;
        @(negedge clk);
        acc = v && (in_ready === 1'b1);
        if (acc && tb_comp) model_xfer(d0, d1, m);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        logic a;
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, a);
    endtask

    task automatic model_clear();
        q.delete();
        tb_comp = 1'b0;
        maddr   = 0;
        msum0   = '0;
        msum1   = '0;
    endtask

    task automatic init_pulse();
        init_enable = 1'b1;
        idle_cyc();
        init_enable = 1'b0;
        model_clear();
    endtask

    task automatic load_word(input int k);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 10 && !a; t++) cyc(1'b1, wt0[k], wt1[k], 1'b0, 1'b1, a);
        nvec++;
        if (!a) begin
            nerr++;
            $display("FAIL load_accept: word %0d got not accepted want accepted", k);
        end
    endtask

    task automatic load_weights();
        init_pulse();
        for (int k = 0; k < DEPTH; k++) begin
            if (k == DEPTH-1) begin
                nvec++;
                if (init_done !== 1'b0) begin
                    nerr++;
                    $display("FAIL init_done_early: got %b want 0", init_done);
                end
            end
            load_word(k);
        end
        nvec++;
        if (init_done !== 1'b1) begin
            nerr++;
            $display("FAIL init_done_set: got %b want 1", init_done);
        end
        tb_comp = 1'b1;
    endtask

    task automatic send(input logic [15:0] d0, input logic [15:0] d1, input logic m);
        logic a;
        a = 1'b0;
        for (int t = 0; t < 10 && !a; t++) cyc(1'b1, d0, d1, m, 1'b1, a);
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && q.size() != 0; t++) idle_cyc();
        nvec++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: got %0d results outstanding want 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; init_enable = 1'b0; pe_ce = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        nvec += 5;
        if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (last_out !== 1'b0) begin nerr++; $display("FAIL rst_last_out: got %b want 0", last_out); end
        if (data_out !== '0) begin nerr++; $display("FAIL rst_data_out: got %h want 0", data_out); end
        if (init_done !== 1'b0) begin nerr++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        if (in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_mode0();
        for (int k = 0; k < DEPTH; k++) begin wt0[k] = 16'(k+1); wt1[k] = 16'(k+1); end
        load_weights();
        for (int k = 0; k < DEPTH; k++) send(16'd3, 16'd3, 1'b0);
        drain();
    endtask

    task automatic test_mode1();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < DEPTH; k++) send(16'd2, 16'd2, 1'b1);
        drain();
    endtask

    task automatic test_stall();
        logic [73:0] snap;
        logic        snapv, a;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 10) begin
                snap  = data_out;
                snapv = out_valid;
                for (int s = 0; s < 3; s++) begin
                    cyc(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, a);
                    nvec++;
                    if (a || data_out !== snap || out_valid !== snapv) begin
                        nerr++;
                        $display("FAIL stall_freeze: accepted %b data_out got %h want %h out_valid got %b want %b",
                                 a, data_out, snap, out_valid, snapv);
                    end
                end
            end
            send(16'd3, 16'd3, 1'b0);
        end
        drain();
    endtask

    task automatic test_reinit_flush();
        send(16'd5, 16'd7, 1'b0);
        init_pulse();
        for (int s = 0; s < 3; s++) begin
            idle_cyc();
            nvec++;
            if (out_valid !== 1'b0 || init_done !== 1'b0) begin
                nerr++;
                $display("FAIL reinit_flush: out_valid got %b init_done got %b want 0 0", out_valid, init_done);
            end
        end
    endtask

    task automatic test_reset_midload();
        for (int k = 0; k < DEPTH; k++) begin wt0[k] = 16'h1111; wt1[k] = 16'h2222; end
        for (int k = 0; k < 10; k++) load_word(k);
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin wt0[k] = 16'hFFFF; wt1[k] = 16'hFFFF; end
        load_weights();
        for (int k = 0; k < DEPTH; k++) send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();
    endtask

    task automatic test_approx();
        for (int k = 0; k < DEPTH; k++) begin wt0[k] = 16'h00FF; wt1[k] = 16'(k * 16'h0101); end
        load_weights();
        for (int k = 0; k < DEPTH; k++) send(16'h00FF, 16'h00FF, 1'b0);
        drain();
    endtask

    task automatic test_random();
        int   sent;
        logic a;
        for (int k = 0; k < DEPTH; k++) begin wt0[k] = 16'($urandom); wt1[k] = 16'($urandom); end
        load_weights();
        sent = 0;
        while (sent < 3*DEPTH) begin
            cyc($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, a);
            if (a) sent++;
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0; pe_ce = 1'b1; init_enable = 1'b0; mode = 1'b0; in_valid = 1'b0; data_in = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_mode0();
        test_mode1();
        test_stall();
        test_reinit_flush();
        test_reset_midload();
        test_approx();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
